data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Responder end of the CPU data-memory port. It serves the core's load/store requests, which carry chip enable, write enable, address, 4-bit byte select and write data.
- Contains a byte-lane-writable word RAM and a small MMIO window:
  - an output byte FIFO with a valid/ready drain port,
  - a free-running cycle counter,
  - a sticky error/status register.
- Sits beside the core in the SoC top, wired directly to the core's mem_* port.

Parameters:
- RAM_AW, 10, word-address width; RAM holds 2**RAM_AW 32-bit words.
- TX_DEPTH, 8, output FIFO depth in bytes; power of two, at least 2.
- TX_CW, 4, FIFO count width; equals log2(TX_DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce_i  in  1  request valid (core mem_ce).
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address; bits [1:0] ignored.
- sel_i  in  4  byte-lane enables; sel_i[i] covers data bits [8i+7:8i].
- data_i  in  32  store data.
- data_o  out  32  load data, combinational, valid in the same cycle.
- tx_data_o  out  8  FIFO head byte.
- tx_valid_o  out  1  FIFO not empty.
- tx_ready_i  in  1  sink accepts the head byte.
- err_o  out  1  OR of the sticky error flags.

Behaviour:
- Decode:
  - MMIO when addr_i[31:16] == 16'hFFFF.
  - Otherwise RAM, at index addr_i[RAM_AW+1:2]. Higher bits are ignored, so the RAM aliases modulo its size.
- RAM write:
  - Happens at the clk rising edge when ce_i & we_i, for each lane whose sel_i bit is set.
  - sel_i == 0 writes nothing.
- RAM read:
  - Combinational: data_o = full word when ce_i & ~we_i.
  - Lane extraction and sign extension are done by the core.
  - Read-during-write to the same word returns the old contents.
- data_o = 0 whenever ce_i = 0, we_i = 1, or the address is an unmapped MMIO offset.
- MMIO map (offset = addr_i[15:0]):
  - 0x0000 TXDATA:
    - Write with sel_i[0] pushes data_i[7:0].
    - Write with sel_i[0]=0 is ignored.
    - Reads return 0.
  - 0x0004 STATUS:
    - Read layout: [31:16]=0, [15:8]=count zero-extended, [7:3]=0, [2]=misalign flag, [1]=overflow flag, [0]=full.
    - Write with data_i[1]=1 clears overflow; data_i[2]=1 clears misalign.
  - 0x0008 CYCLES: read-only 32-bit counter. Increments every clk and wraps 0xFFFFFFFF -> 0. Writes are ignored.
  - Any other offset: reads return 0, writes are ignored; no error is raised.
- FIFO:
  - First-word-fall-through: tx_data_o = head byte; tx_valid_o = (count != 0).
  - Pop on tx_valid_o & tx_ready_i.
  - A push is accepted when count < TX_DEPTH, or when a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - A push rejected while full sets overflow (sticky) and drops the byte.
  - Pointers wrap modulo TX_DEPTH.
  - tx_ready_i with an empty FIFO has no effect.
- Register timing: all updates take effect at the clock edge. A STATUS read in the same cycle as a push shows the pre-edge count.
- Reset (asynchronous, immediate):
  - FIFO pointers and count = 0; tx_valid_o = 0; tx_data_o = 0.
  - Overflow and misalign flags = 0; err_o = 0; cycle counter = 0.
  - RAM contents are NOT reset.
  - A reset asserted mid-drain discards the FIFO contents.

Optional Feature:
- DMEM_ALIGN_CHK_EN defined:
  - A request with ce_i = 1 sets misalign (sticky) when sel_i is not one of: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - The access itself still proceeds.
  - err_o = overflow | misalign.
- Not defined: misalign is tied to 0 and STATUS[2] reads 0.

Decomposition:
- Shared defines file holds:
  - MMIO base 16'hFFFF,
  - offset constants TXDATA / STATUS / CYCLES,
  - STATUS bit positions,
  - the `RegBus width macro, which is reused for data ports.
- One sub-module is natural: byte_fifo (parameterised depth and width, FWFT, push/pop/full/empty/count). It is instantiated once for TX.

Test Plan:
- Store 0xDEADBEEF sel=1111 to 0x40, then store 0x000000AA sel=0001 to 0x40, then load 0x40 -> data_o = 0xDEADBEAA; a load of 0x40 + (4 << RAM_AW) also returns 0xDEADBEAA (alias).
- With tx_ready_i=0, push 0x41, 0x42, 0x43 to 0xFFFF0000 -> tx_valid_o=1, tx_data_o=0x41, STATUS=0x00000300; raise tx_ready_i for 3 cycles -> bytes 0x41, 0x42, 0x43 in order, then tx_valid_o=0.
- Push TX_DEPTH+1 bytes with no drain -> STATUS = (TX_DEPTH << 8) | 0x3, err_o=1; write 0x2 to STATUS -> bit1 clears, err_o=0.
- FIFO full with tx_ready_i=1 while a push occurs -> count stays TX_DEPTH, no overflow, and the pushed byte appears last.
- Release reset, read CYCLES at cycle N and again at N+5 -> difference = 5; assert rst mid-FIFO-drain -> tx_valid_o=0 immediately and STATUS=0.
- With DMEM_ALIGN_CHK_EN, store with sel=0110 -> STATUS[2]=1, err_o=1, and the RAM lanes are still written; without the macro -> STATUS[2]=0.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared definitions for the data-memory responder.
//   - `RegBus      : data-port bit range, reused for 32-bit data ports
//   - MMIO_BASE     : addr[31:16] value that selects the MMIO window
//   - OFF_*         : MMIO register offsets (addr[15:0])
//   - ST_*          : STATUS register bit positions
//   - mem_req_t     : bundled core request
//   - tgt_t         : decoded access target
//   - sel_legal()   : byte-select patterns accepted by the alignment checker
//                     (used only when DMEM_ALIGN_CHK_EN is defined)

`ifndef DATA_MEM_RESP_DEFS
`define DATA_MEM_RESP_DEFS
`define RegBus 31:0
`endif

package data_mem_resp_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hFFFF;
    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLES = 16'h0008;

    localparam int ST_FULL    = 0;
    localparam int ST_OVF     = 1;
    localparam int ST_MIS     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef struct packed {
        logic             ce;
        logic             we;
        logic [`RegBus]   addr;
        logic [3:0]       sel;
        logic [`RegBus]   data;
    } mem_req_t;

    typedef enum logic [2:0] {
        T_RAM,
        T_TXDATA,
        T_STATUS,
        T_CYCLES,
        T_NONE
    } tgt_t;

    // Naturally aligned byte, halfword and word lane patterns.
    function automatic logic sel_legal(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_byte_fifo.sv
// data_mem_resp_byte_fifo: first-word-fall-through FIFO.
//   clk, rst    : clock, async active-high reset (pointers/count cleared)
//   push        : push request; accepted when not full or when popping
//   push_data   : data for push
//   push_ok     : push was accepted this cycle
//   pop         : pop request; ignored while empty
//   head        : head entry, forced to 0 while empty
//   full, empty : occupancy flags
//   count       : number of stored entries (0..DEPTH)

module data_mem_resp_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (~full | pop_ok);
    assign count   = cnt;
    // Storage is not reset, so mask the head to keep the output clean.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: responder for the core data-memory port.
// Word RAM (byte-lane writable, combinational read) plus an MMIO window at
// addr[31:16] == 16'hFFFF holding TXDATA (byte FIFO push), STATUS and CYCLES.
//   clk, rst     : clock, async active-high reset
//   ce_i, we_i   : request valid, store(1)/load(0)
//   addr_i       : byte address, [1:0] ignored
//   sel_i        : byte-lane enables
//   data_i       : store data
//   data_o       : load data, same cycle; 0 when not a load hit
//   tx_data_o    : FIFO head byte
//   tx_valid_o   : FIFO non-empty
//   tx_ready_i   : sink accepts head byte
//   err_o        : OR of sticky error flags
// Build option: define DMEM_ALIGN_CHK_EN to enable the byte-select alignment
// checker (STATUS[2]); otherwise the misalign flag reads 0.

module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int TX_DEPTH = 8,
    parameter int TX_CW    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_i,
    input  logic           we_i,
    input  logic [`RegBus] addr_i,
    input  logic [3:0]     sel_i,
    input  logic [`RegBus] data_i,
    output logic [`RegBus] data_o,
    output logic [7:0]     tx_data_o,
    output logic           tx_valid_o,
    input  logic           tx_ready_i,
    output logic           err_o
);

    mem_req_t          req;
    tgt_t              tgt;
    logic [15:0]       off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_wr;
    logic              st_wr;
    logic              tx_push, tx_push_ok, tx_pop, tx_full, tx_empty;
    logic [TX_CW-1:0]  tx_count;
    logic [3:0][7:0]   ram_rd;
    logic [`RegBus]    status_word;
    logic [`RegBus]    cycles;
    logic              ovf, mis;
    logic              unused_addr;

    assign req = '{ce: ce_i, we: we_i, addr: addr_i, sel: sel_i, data: data_i};
    assign off = req.addr[15:0];
    // Upper address bits are ignored so the RAM aliases modulo its size.
    assign ram_idx = req.addr[RAM_AW+1:2];
    assign unused_addr = ^req.addr[1:0];

    always_comb begin
        tgt = T_NONE;
        if (req.addr[31:16] != MMIO_BASE) begin
            tgt = T_RAM;
        end else begin
            case (off)
                OFF_TXDATA: tgt = T_TXDATA;
                OFF_STATUS: tgt = T_STATUS;
                OFF_CYCLES: tgt = T_CYCLES;
                default:    tgt = T_NONE;
            endcase
        end
    end

    assign ram_wr  = req.ce & req.we & (tgt == T_RAM);
    assign st_wr   = req.ce & req.we & (tgt == T_STATUS);
    assign tx_push = req.ce & req.we & (tgt == T_TXDATA) & req.sel[0];
    assign tx_pop  = tx_valid_o & tx_ready_i;

    // One byte-wide array per lane keeps each lane's write enable independent.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [2**RAM_AW];

        always_ff @(posedge clk) begin
            if (ram_wr && req.sel[l]) mem[ram_idx] <= req.data[8*l +: 8];
        end

        // Read sees pre-edge contents, so read-during-write returns old data.
        assign ram_rd[l] = mem[ram_idx];
    end

    data_mem_resp_byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8),
        .CW    (TX_CW)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (req.data[7:0]),
        .push_ok   (tx_push_ok),
        .pop       (tx_pop),
        .head      (tx_data_o),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_valid_o = ~tx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycles <= '0;
        else     cycles <= cycles + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               ovf <= 1'b0;
        else if (tx_push && !tx_push_ok)       ovf <= 1'b1;
        else if (st_wr && req.data[ST_OVF])    ovf <= 1'b0;
    end

`ifdef DMEM_ALIGN_CHK_EN
    // A new misalign event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 mis <= 1'b0;
        else if (req.ce && !sel_legal(req.sel)) mis <= 1'b1;
        else if (st_wr && req.data[ST_MIS])     mis <= 1'b0;
    end
`else
    assign mis = 1'b0;
`endif

    assign err_o = ovf | mis;

    always_comb begin
        status_word                         = '0;
        status_word[ST_CNT_LSB +: TX_CW]    = tx_count;
        status_word[ST_MIS]                 = mis;
        status_word[ST_OVF]                 = ovf;
        status_word[ST_FULL]                = tx_full;
    end

    always_comb begin
        data_o = '0;
        if (req.ce && !req.we) begin
            case (tgt)
                T_RAM:    data_o = ram_rd;
                T_STATUS: data_o = status_word;
                T_CYCLES: data_o = cycles;
                default:  data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0, we_i = 1'b0, tx_ready_i = 1'b0;
    logic [31:0] addr_i = '0, data_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, err_o;

    int total = 0;
    int bad   = 0;

    data_mem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .sel_i      (sel_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; one rising edge commits the store.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF;
        #1 q = data_o;
        @(negedge clk);
        ce_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q, c1, c2;
        logic        mis_en;
`ifdef DMEM_ALIGN_CHK_EN
        mis_en = 1'b1;
`else
        mis_en = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_data",  32'(tx_data_o),  32'd0);
        check("rst_err",   32'(err_o),      32'd0);
        rst = 1'b0;
        rd(A_ST, q);  check("rst_status", q, 32'h0);

        // RAM lane writes and aliasing
        wr(32'h40, 32'hDEADBEEF, 4'b1111);
        wr(32'h40, 32'h000000AA, 4'b0001);
        rd(32'h40, q);                check("ram_lane", q, 32'hDEADBEAA);
        rd(32'h40 + (4 << 10), q);    check("ram_alias", q, 32'hDEADBEAA);
        wr(32'h40, 32'h12345678, 4'b0000);
        rd(32'h40, q);                check("ram_sel0", q, 32'hDEADBEAA);

        // FIFO push and ordered drain
        wr(A_TX, 32'h41, 4'b0001);
        wr(A_TX, 32'h42, 4'b0001);
        wr(A_TX, 32'h43, 4'b0001);
        check("tx_valid3", 32'(tx_valid_o), 32'd1);
        check("tx_head3",  32'(tx_data_o),  32'h41);
        rd(A_ST, q);  check("status3", q, 32'h0000_0300);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("drain3", 32'(tx_data_o), 32'h41 + i);
            @(negedge clk);
        end
        #1 check("drain3_empty", 32'(tx_valid_o), 32'd0);
        tx_ready_i = 1'b0;
        wr(A_TX, 32'h55, 4'b0010);
        check("tx_sel0_ignored", 32'(tx_valid_o), 32'd0);
        wr(A_ST, 32'h6, 4'hF);

        // Overflow and clear
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h60 + i, 4'b0001);
        rd(A_ST, q);  check("status_ovf", q, 32'h0000_0803);
        check("err_ovf", 32'(err_o), 32'd1);
        wr(A_ST, 32'h2, 4'hF);
        rd(A_ST, q);  check("status_ovf_clr", q, 32'h0000_0801);
        check("err_clr", 32'(err_o), 32'd0);

        // Cycle counter spacing
        rd(A_CYC, c1);
        repeat (4) @(negedge clk);
        rd(A_CYC, c2);
        check("cycles_delta", c2 - c1, 32'd5);

        // Push while full and popping
        tx_ready_i = 1'b1;
        wr(A_TX, 32'h77, 4'b0001);
        tx_ready_i = 1'b0;
        rd(A_ST, q);  check("status_full_pp", q, 32'h0000_0801);
        check("err_full_pp", 32'(err_o), 32'd0);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check("drain_full", 32'(tx_data_o), (i < 7) ? 32'h61 + i : 32'h77);
            @(negedge clk);
        end
        #1 check("drain_full_empty", 32'(tx_valid_o), 32'd0);
        tx_ready_i = 1'b0;

        // Reset mid-drain
        wr(A_TX, 32'h31, 4'b0001);
        wr(A_TX, 32'h32, 4'b0001);
        wr(A_TX, 32'h33, 4'b0001);
        tx_ready_i = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_valid", 32'(tx_valid_o), 32'd0);
        check("rst_mid_data", 32'(tx_data_o), 32'd0);
        tx_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(A_CYC, q); check("cycles_after_rst", q, 32'd0);
        rd(A_ST, q);  check("status_after_rst", q, 32'h0);

        // Alignment check
        wr(32'h80, 32'h0, 4'b1111);
        wr(32'h80, 32'h11223344, 4'b0110);
        rd(32'h80, q);  check("ram_sel0110", q, 32'h0022_3300);
        rd(A_ST, q);    check("status_mis", q, mis_en ? 32'h4 : 32'h0);
        check("err_mis", 32'(err_o), 32'(mis_en));
        wr(A_ST, 32'h4, 4'hF);
        rd(A_ST, q);    check("status_mis_clr", q, 32'h0);

        // Zero-return cases
        rd(32'hFFFF_0010, q);  check("unmapped_rd", q, 32'h0);
        wr(32'hFFFF_0010, 32'hFFFF_FFFF, 4'hF);
        check("unmapped_err", 32'(err_o), 32'd0);
        rd(A_TX, q);           check("txdata_rd", q, 32'h0);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; sel_i = 4'b0000;
        #1 check("data_on_store", data_o, 32'h0);
        ce_i = 1'b0; we_i = 1'b0;
        #1 check("data_no_ce", data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
